// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory arbiter.
//   arb_state_t : arbiter FSM states
//   requester_t : identifies the two requesters (cpu, dma)
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_DMA
    } requester_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bundle for one memory requester.
//   req   : access request, held until ack
//   wr    : 1 = write, 0 = read
//   addr  : memory address
//   wdata : write data
//   ack   : one-cycle completion pulse
// modport master: requester side; modport slave: arbiter side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;

    modport master (output req, output wr, output addr, output wdata, input ack);
    modport slave  (input req, input wr, input addr, input wdata, output ack);

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single synchronous memory.
//   clk, rst_  : clock, synchronous active-low reset
//   cpu, dma   : requester handshakes (requester 0 and 1)
//   rdata      : read data, valid in the ack cycle
//   mem_rd/wr  : memory strobes, one-hot, high only in ACCESS
//   mem_addr   : memory address (holds between accesses)
//   mem_wdata  : memory write data (holds between accesses)
//   mem_rdata  : memory read data, valid one clk after mem_rd
//   busy       : high whenever the FSM is not IDLE
// RR_MODE = 0: cpu priority with a dma starvation guard (MAX_WAIT, 1..15).
// RR_MODE = 1: round-robin between the two requesters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      dma,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned WAIT_W = 4;

    arb_state_t        state_q, state_d;
    requester_t        win_q, win_d;
    requester_t        last_gnt_q, last_gnt_d;
    logic              wr_q, wr_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              any_req;
    logic              grant_dma;
    logic              dma_owns;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= IDLE;
            win_q       <= REQ_CPU;
            last_gnt_q  <= REQ_DMA;
            wr_q        <= 1'b0;
            wait_cnt_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_gnt_q  <= last_gnt_d;
            wr_q        <= wr_d;
            wait_cnt_q  <= wait_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_gnt_d  = last_gnt_q;
        wr_d        = wr_q;
        wait_d      = wait_cnt_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        rdata_d     = rdata_q;
        grant_dma   = 1'b0;
        any_req     = cpu.req | dma.req;
        dma_owns    = (state_q != IDLE) && (win_q == REQ_DMA);

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (!cpu.req) begin
                        grant_dma = 1'b1;
                    end else if (!dma.req) begin
                        grant_dma = 1'b0;
                    end else if (RR_MODE != 0) begin
                        grant_dma = (last_gnt_q == REQ_CPU);
                    end else begin
                        grant_dma = (wait_cnt_q == WAIT_W'(MAX_WAIT));
                    end
                    // The memory-side address/data registers double as the latch
                    win_d       = grant_dma ? REQ_DMA : REQ_CPU;
                    last_gnt_d  = win_d;
                    wr_d        = grant_dma ? dma.wr : cpu.wr;
                    mem_addr_d  = grant_dma ? dma.addr : cpu.addr;
                    mem_wdata_d = grant_dma ? dma.wdata : cpu.wdata;
                    mem_rd_d    = ~wr_d;
                    mem_wr_d    = wr_d;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                cpu_ack_d = (win_q == REQ_CPU);
                dma_ack_d = (win_q == REQ_DMA);
                state_d   = RESP;
            end
            RESP: begin
                if (!wr_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Starvation guard: count cycles dma waits, clear when it is latched
        if (RR_MODE == 0) begin
            if ((state_q == IDLE) && any_req && grant_dma) begin
                wait_d = '0;
            end else if (dma.req && !dma_owns && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
                wait_d = wait_cnt_q + WAIT_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign cpu.ack   = cpu_ack_q;
    assign dma.ack   = dma_ack_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

    // Memory data arrives in the RESP cycle, so it is forwarded there and held afterwards
    assign rdata = ((state_q == RESP) && !wr_q) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: dut0 is fixed priority, dut1 is round-robin.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        bit         dma;
        bit         chk;
        logic [7:0] rd;
        int         c;
    } ack_exp_t;

    typedef struct {
        bit         wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        int         c;
    } strb_exp_t;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if cpu0 ();
    mem_arbiter_if dma0 ();
    mem_arbiter_if cpu1 ();
    mem_arbiter_if dma1 ();

    logic [7:0] rdata0, rdata1, mem_wdata0, mem_wdata1, mem_rdata0, mem_rdata1;
    logic [4:0] mem_addr0, mem_addr1;
    logic       mem_rd0, mem_rd1, mem_wr0, mem_wr1, busy0, busy1;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RR_MODE(0), .MAX_WAIT(8)) dut0 (
        .clk(clk), .rst_(rst_), .cpu(cpu0), .dma(dma0), .rdata(rdata0),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
    );

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RR_MODE(1), .MAX_WAIT(8)) dut1 (
        .clk(clk), .rst_(rst_), .cpu(cpu1), .dma(dma1), .rdata(rdata1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Synchronous 32x8 memories with a preload port
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    logic       pre_we;
    logic [4:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem0[pre_addr] <= pre_data;
            mem1[pre_addr] <= pre_data;
        end else begin
            if (mem_wr0) mem0[mem_addr0] <= mem_wdata0;
            if (mem_rd0) mem_rdata0 <= mem0[mem_addr0];
            if (mem_wr1) mem1[mem_addr1] <= mem_wdata1;
            if (mem_rd1) mem_rdata1 <= mem1[mem_addr1];
        end
    end

    ack_exp_t  ackq0[$];
    ack_exp_t  ackq1[$];
    strb_exp_t strbq0[$];
    strb_exp_t strbq1[$];

    int n_total = 0;
    int n_pass  = 0;
    bit zero0 = 0, zero1 = 0, bchk0 = 0, bexp0 = 0, done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mon_dut(input int d, input logic ca, input logic da, input logic mr,
                           input logic mw, input logic [4:0] ma, input logic [7:0] mwd,
                           input logic [7:0] rd);
        ack_exp_t  e;
        strb_exp_t s;
        bit        empty;
        if (ca || da) begin
            chk($sformatf("dut%0d_ack_onehot", d), 32'(ca & da), 32'd0);
            empty = (d == 0) ? (ackq0.size() == 0) : (ackq1.size() == 0);
            if (empty) begin
                n_total++;
                $display("FAIL dut%0d_unexpected_ack: cpu_ack=%0b dma_ack=%0b required none (cycle %0d)",
                         d, ca, da, cyc);
            end else begin
                e = (d == 0) ? ackq0.pop_front() : ackq1.pop_front();
                chk($sformatf("dut%0d_ack_dma", d), 32'(da), 32'(e.dma));
                chk($sformatf("dut%0d_ack_cycle", d), 32'(cyc), 32'(e.c));
                if (e.chk) chk($sformatf("dut%0d_rdata", d), 32'(rd), 32'(e.rd));
            end
        end
        if (mr || mw) begin
            chk($sformatf("dut%0d_strobe_onehot", d), 32'(mr & mw), 32'd0);
            empty = (d == 0) ? (strbq0.size() == 0) : (strbq1.size() == 0);
            if (empty) begin
                n_total++;
                $display("FAIL dut%0d_unexpected_strobe: rd=%0b wr=%0b required none (cycle %0d)",
                         d, mr, mw, cyc);
            end else begin
                s = (d == 0) ? strbq0.pop_front() : strbq1.pop_front();
                chk($sformatf("dut%0d_strobe_wr", d), 32'(mw), 32'(s.wr));
                chk($sformatf("dut%0d_strobe_addr", d), 32'(ma), 32'(s.addr));
                chk($sformatf("dut%0d_strobe_cycle", d), 32'(cyc), 32'(s.c));
                if (s.wr) chk($sformatf("dut%0d_strobe_wdata", d), 32'(mwd), 32'(s.wdata));
            end
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents an ack or a strobe
    always @(negedge clk) begin
        mon_dut(0, cpu0.ack, dma0.ack, mem_rd0, mem_wr0, mem_addr0, mem_wdata0, rdata0);
        mon_dut(1, cpu1.ack, dma1.ack, mem_rd1, mem_wr1, mem_addr1, mem_wdata1, rdata1);
        if (zero0)
            chk("dut0_outputs_zero", 32'({cpu0.ack, dma0.ack, mem_rd0, mem_wr0, busy0,
                                          mem_addr0, mem_wdata0, rdata0}), 32'd0);
        if (zero1)
            chk("dut1_outputs_zero", 32'({cpu1.ack, dma1.ack, mem_rd1, mem_wr1, busy1,
                                          mem_addr1, mem_wdata1, rdata1}), 32'd0);
        if (bchk0) chk("dut0_busy", 32'(busy0), 32'(bexp0));
        if (done || cyc > 2000) begin
            if (!done) begin
                n_total++;
                $display("FAIL timeout: cycle %0d reached before stimulus end", cyc);
            end
            chk("pending_acks", 32'(ackq0.size() + ackq1.size()), 32'd0);
            chk("pending_strobes", 32'(strbq0.size() + strbq1.size()), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input int d, input bit dma, input bit c, input logic [7:0] rd, input int at);
        ack_exp_t e;
        e.dma = dma; e.chk = c; e.rd = rd; e.c = at;
        if (d == 0) ackq0.push_back(e); else ackq1.push_back(e);
    endtask

    task automatic push_strb(input int d, input bit wr, input logic [4:0] a, input logic [7:0] wd, input int at);
        strb_exp_t s;
        s.wr = wr; s.addr = a; s.wdata = wd; s.c = at;
        if (d == 0) strbq0.push_back(s); else strbq1.push_back(s);
    endtask

    task automatic drive(input int d, input bit dma, input bit on, input bit wr,
                         input logic [4:0] a, input logic [7:0] wd);
        if (d == 0 && !dma) begin cpu0.req = on; cpu0.wr = wr; cpu0.addr = a; cpu0.wdata = wd; end
        if (d == 0 &&  dma) begin dma0.req = on; dma0.wr = wr; dma0.addr = a; dma0.wdata = wd; end
        if (d == 1 && !dma) begin cpu1.req = on; cpu1.wr = wr; cpu1.addr = a; cpu1.wdata = wd; end
        if (d == 1 &&  dma) begin dma1.req = on; dma1.wr = wr; dma1.addr = a; dma1.wdata = wd; end
    endtask

    // Single isolated access: strobe 1 cycle and ack 2 cycles after issue
    task automatic do_access(input int d, input bit dma, input bit wr, input logic [4:0] a,
                             input logic [7:0] wd, input logic [7:0] exp_rd);
        int k;
        k = cyc;
        drive(d, dma, 1'b1, wr, a, wd);
        push_strb(d, wr, a, wd, k + 1);
        push_ack(d, dma, 1'b1, exp_rd, k + 2);
        tick();
        tick();
        drive(d, dma, 1'b0, wr, a, wd);
        tick();
    endtask

    initial begin
        int k;
        rst_   = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
            drive(d, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        end

        // Reset with memory preload
        tick();
        pre_we = 1'b1; pre_addr = 5'd5;  pre_data = 8'hA7; tick();
        pre_addr = 5'd31; pre_data = 8'h5A; tick();
        pre_addr = 5'd10; pre_data = 8'h11; tick();
        pre_we = 1'b0;
        zero0 = 1'b1; zero1 = 1'b1;
        tick(); tick();
        rst_ = 1'b1;
        tick();
        zero0 = 1'b0; zero1 = 1'b0;

        // cpu read of address 5 with busy profile
        k = cyc;
        drive(0, 1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        push_strb(0, 1'b0, 5'd5, 8'd0, k + 1);
        push_ack(0, 1'b0, 1'b1, 8'hA7, k + 2);
        bchk0 = 1'b1; bexp0 = 1'b0;
        tick(); bexp0 = 1'b1;
        tick(); drive(0, 1'b0, 1'b0, 1'b0, 5'd5, 8'd0);
        tick(); bexp0 = 1'b0;
        tick(); bchk0 = 1'b0;

        // dma write 31 <= 3C (rdata holds A7), then cpu reads it back
        do_access(0, 1'b1, 1'b1, 5'd31, 8'h3C, 8'hA7);
        do_access(0, 1'b0, 1'b0, 5'd31, 8'h00, 8'h3C);

        // Fixed priority under contention: cpu, cpu, cpu, dma, repeating
        k = cyc;
        drive(0, 1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        drive(0, 1'b1, 1'b1, 1'b0, 5'd31, 8'd0);
        for (int i = 0; i < 8; i++) begin
            bit is_dma;
            is_dma = ((i % 4) == 3);
            push_strb(0, 1'b0, is_dma ? 5'd31 : 5'd5, 8'd0, k + 1 + 3 * i);
            push_ack(0, is_dma, 1'b1, is_dma ? 8'h3C : 8'hA7, k + 2 + 3 * i);
        end
        repeat (23) tick();
        drive(0, 1'b0, 1'b0, 1'b0, 5'd5, 8'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 5'd31, 8'd0);
        tick();

        // cpu drops req and changes address during ACCESS; dma wins next
        k = cyc;
        drive(0, 1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        drive(0, 1'b1, 1'b1, 1'b0, 5'd31, 8'd0);
        push_strb(0, 1'b0, 5'd5, 8'd0, k + 1);
        push_ack(0, 1'b0, 1'b1, 8'hA7, k + 2);
        push_strb(0, 1'b0, 5'd31, 8'd0, k + 4);
        push_ack(0, 1'b1, 1'b1, 8'h3C, k + 5);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 5'd7, 8'd0);
        repeat (4) tick();
        drive(0, 1'b1, 1'b0, 1'b0, 5'd31, 8'd0);
        tick();

        // Reset during the ACCESS cycle of a dma write: no ack, outputs cleared
        k = cyc;
        drive(0, 1'b1, 1'b1, 1'b1, 5'd10, 8'h55);
        push_strb(0, 1'b1, 5'd10, 8'h55, k + 1);
        tick();
        rst_ = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        zero0 = 1'b1; zero1 = 1'b1;
        rst_  = 1'b1;
        tick();
        tick();
        zero0 = 1'b0; zero1 = 1'b0;
        do_access(0, 1'b0, 1'b0, 5'd5, 8'd0, 8'hA7);

        // Round-robin contention on dut1: cpu, dma, cpu, dma, 3 cycles apart
        k = cyc;
        drive(1, 1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 5'd31, 8'd0);
        for (int i = 0; i < 4; i++) begin
            bit is_dma;
            is_dma = ((i % 2) == 1);
            push_strb(1, 1'b0, is_dma ? 5'd31 : 5'd5, 8'd0, k + 1 + 3 * i);
            push_ack(1, is_dma, 1'b1, is_dma ? 8'h5A : 8'hA7, k + 2 + 3 * i);
        end
        repeat (11) tick();
        drive(1, 1'b0, 1'b0, 1'b0, 5'd5, 8'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 5'd31, 8'd0);
        repeat (3) tick();

        done = 1'b1;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 32x8 synchronous memory between two requesters:
  - the CPU datapath (requester 0, "cpu")
  - a program loader / debug DMA port (requester 1, "dma")
- Sits between the requesters and the memory. It owns the memory's read strobe, write strobe, address and write-data inputs.
- Each requester uses a req/ack handshake. Arbitration is either fixed-priority or round-robin, selected by parameter. A starvation guard bounds how long dma can wait.

Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- RR_MODE, 0, selects the arbitration policy: 0 = cpu fixed priority with starvation guard; 1 = round-robin
- MAX_WAIT, 8, cycles dma may wait with req high before it is forced to win; legal range 1..15

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_  in  1  synchronous active-low reset
- cpu_req  in  1  cpu access request; held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  cpu address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_wr, dma_addr, dma_wdata, dma_ack: same as the cpu_* ports, for requester 1
- rdata  out  DATA_W  read data, valid in the cycle the ack pulses
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid one clk after mem_rd
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst_ low at a posedge):
  - state = IDLE
  - all outputs = 0
  - wait_cnt = 0, last_gnt = dma (so cpu wins the first round-robin tie)
  - an in-flight access is abandoned: no ack is issued, and mem_wr is low from that edge onward.
- State machine with three states: IDLE, ACCESS, RESP.
  - IDLE: if any req is high, latch the winner and its wr/addr/wdata into internal registers, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (one cycle): mem_addr/mem_wdata come from the latched values; mem_rd = ~wr, mem_wr = wr. Next state is RESP.
  - RESP (one cycle): the winner's ack = 1. For a read, rdata = mem_rdata (registered on entry to RESP, so it is stable during the ack). For a write, rdata holds its previous value. Next state is always IDLE.
- Latency and throughput:
  - req first seen high in IDLE at edge N: strobe in cycle N+1, ack in cycle N+2.
  - Maximum throughput is one access per 3 cycles. A requester holding req across its ack is re-arbitrated in the following IDLE.
- Arbitration, sampled only in IDLE:
  - RR_MODE=0: cpu wins when both requests are high, unless wait_cnt == MAX_WAIT, in which case dma wins.
    - wait_cnt increments each cycle dma_req=1 and dma is not the current winner, saturating at MAX_WAIT.
    - wait_cnt clears when dma is latched as winner.
  - RR_MODE=1: when both requests are high, the requester that is not last_gnt wins; last_gnt updates on each latch. wait_cnt is unused and stays 0.
  - A single active request always wins immediately.
- Outputs are strictly one-hot per cycle: never cpu_ack and dma_ack together, never mem_rd and mem_wr together.
- Protocol violation: if a requester drops req, or changes its fields, after it has been latched, the latched access still completes and the ack still pulses. Request inputs are ignored outside IDLE.
- In IDLE and RESP, mem_rd = mem_wr = 0. mem_addr and mem_wdata hold their last values (no glitching to 0).
- Address wrap: not applicable; addresses pass through unmodified.

Decomposition:
- Shared package (typedefs):
  - arb_state_t enum {IDLE, ACCESS, RESP}
  - requester_t enum {REQ_CPU, REQ_DMA}
  - constants MEM_ADDR_W=5 and MEM_DATA_W=8, reused as parameter defaults
- No sub-module; the FSM, the winner latch and wait_cnt fit in one module.

Test Plan:
- Reset then cpu read: preload mem[5]=8'hA7; cpu_req=1, cpu_wr=0, cpu_addr=5 -> mem_rd high in cycle 1, cpu_ack and rdata=8'hA7 in cycle 2, busy high in cycles 1-2, dma_ack stays 0.
- dma write: dma_req=1, dma_wr=1, dma_addr=31, dma_wdata=8'h3C -> mem_wr high for exactly 1 cycle with mem_addr=31; dma_ack one cycle later; a subsequent cpu read of address 31 returns 8'h3C.
- RR_MODE=0 starvation: cpu_req and dma_req held high continuously, MAX_WAIT=8 -> cpu is granted until wait_cnt reaches 8, then dma is granted once, wait_cnt returns to 0, and the pattern repeats; the dma_ack interval is bounded.
- RR_MODE=1 contention: both requests held high -> acks alternate cpu, dma, cpu, dma, with each ack 3 cycles apart.
- Reset mid-write: rst_ low in the ACCESS cycle of a dma write -> next cycle all outputs are 0, no ack is issued, and memory is written at most on that edge; after rst_ goes high, a cpu read proceeds normally.
- Protocol violation: cpu_req dropped in the ACCESS cycle -> cpu_ack still pulses once; the next IDLE grants dma if dma_req is high.
